irq_pending_latch: RTL and testbench
====================================

// Module: irq_pending_latch
// PURPOSE
//  Captures N raw interrupt/request lines into a pending register, per-bit edge or level mode.
//  Applies the enable mask and drives the registered pending vector into the 8-to-3 priority encoder.
//  The consumer returns the serviced index (the encoder's y) on ack_* to clear that pending bit.
//  Sits directly upstream of the priority encoder in the interrupt/arbitration path.
// PARAMETERS
//  N      8  number of request lines (encoder input width)
//  IDX_W  3  index width, = $clog2(N)
// PORTS
//  clk        in   1      single clock, all flops rising edge
//  rst_n      in   1      asynchronous, active-low reset
//  irq_in     in   N      raw request lines, asynchronous to clk when IRQ_SYNC_EN is defined
//  edge_sel   in   N      per bit: 1 = rising-edge triggered, 0 = level triggered
//  irq_mask   in   N      per bit: 1 = enabled onto pend, 0 = held pending but hidden
//  ack_valid  in   1      1-cycle strobe: the request at ack_idx has been serviced
//  ack_idx    in   IDX_W  index being acknowledged (encoder y)
//  ovf_clr    in   1      clears all overflow flags
//  pend       out  N      registered masked pending vector, drives encoder input i
//  pend_any   out  1      registered, = |pend
//  overflow   out  N      sticky: a new edge arrived while that bit was already pending
// BEHAVIOUR
//  - Reset: all flops clear asynchronously: sample/prev flops, pending p, pend, pend_any, overflow.
//  - Reset asserted mid-operation discards all pending requests at once; nothing is replayed after release.
//  - Sampling: s_q = sampled irq_in; s_d = s_q delayed one cycle; rise = s_q & ~s_d.
//  - s_d resets to 0, so a line already high when reset is released counts as one rising edge.
//  - set[b] = edge_sel[b] ? rise[b] : s_q[b].
//  - clr[b] = ack_valid && ack_idx == b.
//  - p_next[b] = set[b] | (p[b] & ~clr[b]). When set and clr occur in the same cycle, set wins.
//  - An ack while a level line is still high is therefore re-set at once.
//  - ack_idx >= N, or an ack of a non-pending bit, has no effect.
//  - pend <= p_next & irq_mask; pend_any <= |(p_next & irq_mask).
//  - Masked bits keep accumulating in p. A mask change reaches pend at the next edge.
//  - overflow[b] <= 1 when edge_sel[b] & rise[b] & p[b] & ~clr[b].
//  - Otherwise ovf_clr forces all bits to 0; set beats ovf_clr in the same cycle.
//  - Level-mode bits never flag overflow.
//  - Latency, irq_in change to pend: 2 rising edges without IRQ_SYNC_EN, 3 with it.
//  - Latency, ack_valid to pend bit clear: 1 edge.
//  - No FSM; per-bit set/clear registers only. Output width arithmetic is unsigned, N bits throughout.
// CONFIGURATION
//  IRQ_SYNC_EN defined:
//   - Each irq_in bit passes through a 2-flop synchronizer before s_q (3-edge latency).
//   - irq_in may then be fully asynchronous.
//  IRQ_SYNC_EN undefined:
//   - irq_in is registered once directly into s_q (2-edge latency).
//   - irq_in must then be synchronous to clk.
// STRUCTURE
//  - Shared package irq_pkg holds:
//    - constants N_IRQ=8 and IRQ_IDX_W=3;
//    - function idx_to_onehot(idx) used for the clr decode;
//    - localparams EDGE=1'b1 and LEVEL=1'b0 for edge_sel.
//  - Sub-module irq_sync_edge (per bit, generate loop over N) contains:
//    - the optional synchronizer;
//    - the s_q/s_d flops;
//    - outputs level (s_q) and rise.
//  - The top level holds p, pend, pend_any, overflow and the ack decode.
// TESTING
//  T1 Hold rst_n=0 with irq_in=8'hFF, mask=8'hFF -> pend=0, pend_any=0, overflow=0.
//     Release reset with edge_sel=8'hFF -> pend=8'hFF after the stated latency.
//  T2 Level mode: edge_sel=0, mask=8'hFF, irq_in=8'h20 -> pend=8'h20, pend_any=1 after 2 edges (3 with SYNC).
//     Then ack_idx=5 with input still high -> pend stays 8'h20.
//     Then drop input and ack -> pend=0.
//  T3 Edge mode: edge_sel=8'hFF, one-cycle pulse on bit 2 -> pend=8'h04 and held after input drops.
//     Then ack_valid=1, ack_idx=2 -> pend=0 one edge later.
//     ack_idx=3 (not pending) at any point -> no change.
//  T4 Mask: irq_mask=0, edge on bit 7 -> pend=0, pend_any=0.
//     Then irq_mask=8'h80 -> pend=8'h80 at the next edge.
//  T5 Overflow: second rise on bit 0 before ack -> overflow=8'h01; ovf_clr -> overflow=0.
//     Rise coinciding with ack_idx=0 -> pend[0] stays 1, overflow stays 0.
//  T6 Chained with priority_encoder: pend=8'b1001_0000 -> y=7.
//     ack 7 -> y=4; ack 4 -> pend_any=0.
//     Async reset pulse mid-sequence -> pend=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/irq_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package   : irq_pkg                                                        |
// | Purpose   : Shared constants, edge/level selector encodings and the        |
// |             acknowledge-index decode helper for the pending latch.         |
// | Revision  : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
package irq_pkg;

    // Number of request lines and the width of an index into them.
    localparam int N_IRQ     = 8;
    localparam int IRQ_IDX_W = 3;

    // Per-bit trigger mode encodings for edge_sel.
    localparam logic EDGE  = 1'b1;
    localparam logic LEVEL = 1'b0;

    // One-hot decode of an acknowledge index. Indices with no matching line
    // decode to all zeros, so an out-of-range ack clears nothing.
    function automatic logic [N_IRQ-1:0] idx_to_onehot(input logic [IRQ_IDX_W-1:0] idx);
        logic [N_IRQ-1:0] v;
        v = '0;
        for (int i = 0; i < N_IRQ; i++) begin
            if (idx == IRQ_IDX_W'(i)) begin
                v[i] = 1'b1;
            end
        end
        return v;
    endfunction

endpackage : irq_pkg
`default_nettype wire

// File: rtl/irq_sync_edge.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module    : irq_sync_edge                                                  |
// | Purpose   : Single-line sampler. Registers one raw request line into s_q,  |
// |             keeps a one-cycle delayed copy s_d and reports the level and a |
// |             rising-edge pulse.                                             |
// | Config    : IRQ_SYNC_EN - when defined, the line passes through a two-flop |
// |             synchronizer whose second stage is s_q, so the input may be    |
// |             fully asynchronous to clk.                                     |
// | Revision  : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
module irq_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic irq_in,
    output logic level,
    output logic rise
);

    logic r_s_q;
    logic r_s_d;

`ifdef IRQ_SYNC_EN
    logic r_meta;

    // Two-flop synchronizer: r_meta absorbs metastability, r_s_q is the stable sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 1'b0;
            r_s_q  <= 1'b0;
        end else begin
            r_meta <= irq_in;
            r_s_q  <= r_meta;
        end
    end
`else
    // Input is already synchronous to clk: a single sampling register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s_q <= 1'b0;
        end else begin
            r_s_q <= irq_in;
        end
    end
`endif

    // Delayed sample; clearing to 0 makes a line held high through reset count as one edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s_d <= 1'b0;
        end else begin
            r_s_d <= r_s_q;
        end
    end

    assign level = r_s_q;
    assign rise  = r_s_q & ~r_s_d;

endmodule : irq_sync_edge
`default_nettype wire

// File: rtl/irq_pending_latch.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module    : irq_pending_latch                                              |
// | Purpose   : Captures N request lines into a pending register (per-bit edge |
// |             or level trigger), applies the enable mask and presents the    |
// |             registered pending vector to the downstream priority encoder.  |
// |             The consumer acknowledges the serviced index to clear its bit. |
// |             Sticky overflow flags record edges lost on already-pending     |
// |             edge-mode bits.                                                |
// | Config    : IRQ_SYNC_EN - adds a two-flop synchronizer per input line      |
// |             (irq_in to pend latency becomes 3 edges instead of 2).         |
// | Revision  : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
module irq_pending_latch
    import irq_pkg::*;
#(
    parameter int N     = N_IRQ,
    parameter int IDX_W = IRQ_IDX_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     irq_in,
    input  logic [N-1:0]     edge_sel,
    input  logic [N-1:0]     irq_mask,
    input  logic             ack_valid,
    input  logic [IDX_W-1:0] ack_idx,
    input  logic             ovf_clr,
    output logic [N-1:0]     pend,
    output logic             pend_any,
    output logic [N-1:0]     overflow
);

    logic [N-1:0]     w_level;
    logic [N-1:0]     w_rise;
    logic [N-1:0]     w_set;
    logic [N-1:0]     w_clr;
    logic [N-1:0]     w_p_next;
    logic [N-1:0]     w_ovf_set;
    logic [N-1:0]     w_pend_next;
    logic [N_IRQ-1:0] w_dec;
    logic [N-1:0]     r_p;

    // Acknowledge decode, shared by every bit.
    assign w_dec = idx_to_onehot(IRQ_IDX_W'(ack_idx));

    generate
        for (genvar b = 0; b < N; b++) begin : g_bit
            irq_sync_edge u_sync (
                .clk    (clk),
                .rst_n  (rst_n),
                .irq_in (irq_in[b]),
                .level  (w_level[b]),
                .rise   (w_rise[b])
            );

            // Lines beyond the decoder's reach can never be acknowledged by index.
            if (b < N_IRQ) begin : g_dec
                assign w_clr[b] = ack_valid & w_dec[b % N_IRQ];
            end else begin : g_nodec
                assign w_clr[b] = 1'b0;
            end

            assign w_set[b] = (edge_sel[b] == EDGE) ? w_rise[b] : w_level[b];
        end
    endgenerate

    // Set wins over clear, so an acked level line that is still high re-pends at once.
    assign w_p_next    = w_set | (r_p & ~w_clr);
    assign w_pend_next = w_p_next & irq_mask;

    // A new edge on a bit that is already pending and not being serviced is a lost request.
    assign w_ovf_set   = edge_sel & w_rise & r_p & ~w_clr;

    // Unmasked pending accumulator plus the registered, masked view of it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_p      <= '0;
            pend     <= '0;
            pend_any <= 1'b0;
        end else begin
            r_p      <= w_p_next;
            pend     <= w_pend_next;
            pend_any <= |w_pend_next;
        end
    end

    // Sticky overflow flags: a new overflow beats a simultaneous bulk clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= '0;
        end else begin
            for (int b = 0; b < N; b++) begin
                if (w_ovf_set[b]) begin
                    overflow[b] <= 1'b1;
                end else if (ovf_clr) begin
                    overflow[b] <= 1'b0;
                end
            end
        end
    end

endmodule : irq_pending_latch
`default_nettype wire

// File: tb/tb_irq_pending_latch.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module    : tb_irq_pending_latch                                           |
// | Purpose   : Directed self-checking bench for irq_pending_latch.            |
// | Config    : honours IRQ_SYNC_EN for the input-to-pend latency.             |
// | Revision  : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
module tb_irq_pending_latch;

`ifdef IRQ_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    logic       clk;
    logic       rst_n;
    logic [7:0] irq_in;
    logic [7:0] edge_sel;
    logic [7:0] irq_mask;
    logic       ack_valid;
    logic [2:0] ack_idx;
    logic       ovf_clr;
    logic [7:0] pend;
    logic       pend_any;
    logic [7:0] overflow;

    int n_checks = 0;
    int n_pass   = 0;

    irq_pending_latch dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .irq_in    (irq_in),
        .edge_sel  (edge_sel),
        .irq_mask  (irq_mask),
        .ack_valid (ack_valid),
        .ack_idx   (ack_idx),
        .ovf_clr   (ovf_clr),
        .pend      (pend),
        .pend_any  (pend_any),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference priority encoder: highest set index wins.
    function automatic int enc_y(input logic [7:0] v);
        int y;
        y = 0;
        for (int i = 0; i < 8; i++) if (v[i]) y = i;
        return y;
    endfunction

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0; irq_in = 8'h00; ack_valid = 1'b0; ack_idx = 3'd0; ovf_clr = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(2);
    endtask

    // Drive a one-cycle high pulse on the given lines.
    task automatic pulse(input logic [7:0] v);
        irq_in = v;
        tick(LAT - 1);
        irq_in = 8'h00;
        tick(1);
    endtask

    task automatic ack(input logic [2:0] idx);
        ack_valid = 1'b1; ack_idx = idx;
        tick(1);
        ack_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; irq_in = 8'hFF; irq_mask = 8'hFF; edge_sel = 8'hFF;
        ack_valid = 1'b0; ack_idx = 3'd0; ovf_clr = 1'b0;
        tick(3);
        n_checks++; if (pend !== 8'h00) $display("FAIL reset_pend: got %h expected 00", pend); else n_pass++;
        n_checks++; if (pend_any !== 1'b0) $display("FAIL reset_pend_any: got %b expected 0", pend_any); else n_pass++;
        n_checks++; if (overflow !== 8'h00) $display("FAIL reset_overflow: got %h expected 00", overflow); else n_pass++;
        rst_n = 1'b1;
        tick(LAT - 1);
        n_checks++; if (pend !== 8'h00) $display("FAIL release_early: got %h expected 00", pend); else n_pass++;
        tick(1);
        n_checks++; if (pend !== 8'hFF) $display("FAIL release_edge: got %h expected ff", pend); else n_pass++;
        n_checks++; if (pend_any !== 1'b1) $display("FAIL release_any: got %b expected 1", pend_any); else n_pass++;
    endtask

    task automatic test_level();
        do_reset();
        edge_sel = 8'h00; irq_mask = 8'hFF;
        irq_in = 8'h20;
        tick(LAT - 1);
        n_checks++; if (pend !== 8'h00) $display("FAIL level_early: got %h expected 00", pend); else n_pass++;
        tick(1);
        n_checks++; if (pend !== 8'h20) $display("FAIL level_set: got %h expected 20", pend); else n_pass++;
        n_checks++; if (pend_any !== 1'b1) $display("FAIL level_any: got %b expected 1", pend_any); else n_pass++;
        ack(3'd5);
        n_checks++; if (pend !== 8'h20) $display("FAIL level_ack_high: got %h expected 20", pend); else n_pass++;
        irq_in = 8'h00;
        tick(LAT + 1);
        n_checks++; if (pend !== 8'h20) $display("FAIL level_hold: got %h expected 20", pend); else n_pass++;
        ack(3'd5);
        n_checks++; if (pend !== 8'h00) $display("FAIL level_ack_low: got %h expected 00", pend); else n_pass++;
        n_checks++; if (pend_any !== 1'b0) $display("FAIL level_any_clr: got %b expected 0", pend_any); else n_pass++;
    endtask

    task automatic test_edge();
        do_reset();
        edge_sel = 8'hFF; irq_mask = 8'hFF;
        pulse(8'h04);
        n_checks++; if (pend !== 8'h04) $display("FAIL edge_set: got %h expected 04", pend); else n_pass++;
        tick(2);
        n_checks++; if (pend !== 8'h04) $display("FAIL edge_hold: got %h expected 04", pend); else n_pass++;
        ack(3'd3);
        n_checks++; if (pend !== 8'h04) $display("FAIL edge_ack_other: got %h expected 04", pend); else n_pass++;
        ack(3'd2);
        n_checks++; if (pend !== 8'h00) $display("FAIL edge_ack: got %h expected 00", pend); else n_pass++;
        n_checks++; if (overflow !== 8'h00) $display("FAIL edge_no_ovf: got %h expected 00", overflow); else n_pass++;
    endtask

    task automatic test_mask();
        do_reset();
        edge_sel = 8'hFF; irq_mask = 8'h00;
        pulse(8'h80);
        tick(1);
        n_checks++; if (pend !== 8'h00) $display("FAIL mask_hidden: got %h expected 00", pend); else n_pass++;
        n_checks++; if (pend_any !== 1'b0) $display("FAIL mask_any: got %b expected 0", pend_any); else n_pass++;
        irq_mask = 8'h80;
        tick(1);
        n_checks++; if (pend !== 8'h80) $display("FAIL mask_reveal: got %h expected 80", pend); else n_pass++;
        n_checks++; if (pend_any !== 1'b1) $display("FAIL mask_reveal_any: got %b expected 1", pend_any); else n_pass++;
        irq_mask = 8'hFF;
    endtask

    task automatic test_overflow();
        do_reset();
        edge_sel = 8'hFF; irq_mask = 8'hFF;
        pulse(8'h01);
        n_checks++; if (overflow !== 8'h00) $display("FAIL ovf_first: got %h expected 00", overflow); else n_pass++;
        pulse(8'h01);
        n_checks++; if (overflow !== 8'h01) $display("FAIL ovf_second: got %h expected 01", overflow); else n_pass++;
        n_checks++; if (pend !== 8'h01) $display("FAIL ovf_pend: got %h expected 01", pend); else n_pass++;
        ovf_clr = 1'b1;
        tick(1);
        ovf_clr = 1'b0;
        n_checks++; if (overflow !== 8'h00) $display("FAIL ovf_clr: got %h expected 00", overflow); else n_pass++;
        // Rise arrives on the same edge that acks bit 0: set wins, no overflow.
        irq_in = 8'h01;
        tick(LAT - 1);
        irq_in = 8'h00; ack_valid = 1'b1; ack_idx = 3'd0;
        tick(1);
        ack_valid = 1'b0;
        n_checks++; if (pend !== 8'h01) $display("FAIL ovf_ack_pend: got %h expected 01", pend); else n_pass++;
        n_checks++; if (overflow !== 8'h00) $display("FAIL ovf_ack_flag: got %h expected 00", overflow); else n_pass++;
        // New overflow beats a simultaneous clear.
        irq_in = 8'h01;
        tick(LAT - 1);
        irq_in = 8'h00; ovf_clr = 1'b1;
        tick(1);
        ovf_clr = 1'b0;
        n_checks++; if (overflow !== 8'h01) $display("FAIL ovf_beats_clr: got %h expected 01", overflow); else n_pass++;
    endtask

    task automatic test_chain();
        do_reset();
        edge_sel = 8'hFF; irq_mask = 8'hFF;
        pulse(8'h90);
        n_checks++; if (pend !== 8'h90) $display("FAIL chain_pend: got %h expected 90", pend); else n_pass++;
        n_checks++; if (enc_y(pend) !== 7) $display("FAIL chain_y7: got %0d expected 7", enc_y(pend)); else n_pass++;
        ack(3'(enc_y(pend)));
        n_checks++; if (pend !== 8'h10) $display("FAIL chain_after7: got %h expected 10", pend); else n_pass++;
        n_checks++; if (enc_y(pend) !== 4) $display("FAIL chain_y4: got %0d expected 4", enc_y(pend)); else n_pass++;
        ack(3'(enc_y(pend)));
        n_checks++; if (pend_any !== 1'b0) $display("FAIL chain_empty: got %b expected 0", pend_any); else n_pass++;
        // Asynchronous reset mid-cycle clears outputs without a clock edge.
        pulse(8'h09);
        n_checks++; if (pend !== 8'h09) $display("FAIL chain_refill: got %h expected 09", pend); else n_pass++;
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++; if (pend !== 8'h00) $display("FAIL async_rst_pend: got %h expected 00", pend); else n_pass++;
        n_checks++; if (pend_any !== 1'b0) $display("FAIL async_rst_any: got %b expected 0", pend_any); else n_pass++;
        tick(1);
        rst_n = 1'b1;
        tick(LAT + 1);
        n_checks++; if (pend !== 8'h00) $display("FAIL async_no_replay: got %h expected 00", pend); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_level();
        test_edge();
        test_mask();
        test_overflow();
        test_chain();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_irq_pending_latch
`default_nettype wire
